mod4591_share_arb: RTL and testbench

// Round-robin arbiter/sequencer sharing one pipelined mod4591 reducer among
// N_REQ requesters (e.g. NTRU multiplier lanes). At most one request issues per

---
 rtl/mod4591_share_arb_pkg.sv | 18 +
 rtl/mod4591_share_arb_if.sv | 30 +++
 rtl/mod4591.sv | 50 +++++
 rtl/mod4591_share_arb_rr_grant.sv | 33 +++
 rtl/mod4591_share_arb.sv | 102 ++++++++++
 tb/tb_mod4591_share_arb.sv | 254 +++++++++++++++++++++++++
 6 files changed

// File: rtl/mod4591_share_arb_pkg.sv
// rtl/mod4591_share_arb_pkg.sv - shared constants for the mod4591 share arbiter
package mod4591_share_arb_pkg;

    localparam int unsigned NTRU_Q      = 4591;
    localparam int unsigned P_WIDTH_DEF = 16;
    localparam int unsigned RED_LAT     = 3;

    // Barrett constant: q_est = (x * M) >> K never exceeds the true quotient
    // and falls short by at most one for x < 2^32.
    localparam int unsigned  BARRETT_K = 37;
    localparam logic [63:0]  BARRETT_M = (64'd1 << BARRETT_K) / 64'(NTRU_Q);

    // Round-robin successor of a lane index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mod4591_share_arb_if.sv
// rtl/mod4591_share_arb_if.sv - request/response bus of the shared reducer
interface mod4591_share_arb_if #(
    parameter int N_REQ   = 4,
    parameter int TAG_W   = 4,
    parameter int P_WIDTH = 16
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]           Req_valid;
    logic [N_REQ*2*P_WIDTH-1:0] Req_data;
    logic [N_REQ*TAG_W-1:0]     Req_tag;
    logic [N_REQ-1:0]           Req_ready;
    logic                       Hold;
    logic                       Res_valid;
    logic [ID_W-1:0]            Res_id;
    logic [TAG_W-1:0]           Res_tag;
    logic [P_WIDTH-1:0]         Res_data;
    logic                       Busy;

    modport master (
        output Req_valid, Req_data, Req_tag, Hold,
        input  Req_ready, Res_valid, Res_id, Res_tag, Res_data, Busy
    );

    modport slave (
        input  Req_valid, Req_data, Req_tag, Hold,
        output Req_ready, Res_valid, Res_id, Res_tag, Res_data, Busy
    );

endinterface

// File: rtl/mod4591.sv
// rtl/mod4591.sv - three-stage pipelined Barrett reduction modulo 4591
module mod4591
    import mod4591_share_arb_pkg::*;
#(
    parameter int P_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [2*P_WIDTH-1:0]   In,
    output logic [P_WIDTH-1:0]     Out
);
    localparam int IN_W = 2 * P_WIDTH;

    logic [IN_W-1:0]     x1_q, x1_d;
    logic [IN_W-1:0]     x2_q, x2_d;
    logic [26:0]         q2_q, q2_d;
    logic [P_WIDTH-1:0]  out_q, out_d;
    logic [63:0]         prod;
    logic [63:0]         rem;

    // Stage math: capture, estimate quotient, subtract and correct.
    always_comb begin
        x1_d  = In;
        prod  = {{(64-IN_W){1'b0}}, x1_q} * BARRETT_M;
        x2_d  = x1_q;
        q2_d  = prod[63:BARRETT_K];
        rem   = {{(64-IN_W){1'b0}}, x2_q} - ({37'd0, q2_q} * 64'(NTRU_Q));
        if (rem >= 64'(NTRU_Q)) rem = rem - 64'(NTRU_Q);
        if (rem >= 64'(NTRU_Q)) rem = rem - 64'(NTRU_Q);
        out_d = rem[P_WIDTH-1:0];
    end

    // Pipeline registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x1_q  <= '0;
            x2_q  <= '0;
            q2_q  <= '0;
            out_q <= '0;
        end else begin
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            q2_q  <= q2_d;
            out_q <= out_d;
        end
    end

    assign Out = out_q;

endmodule

// File: rtl/mod4591_share_arb_rr_grant.sv
// rtl/mod4591_share_arb_rr_grant.sv - combinational round-robin picker
module mod4591_share_arb_rr_grant #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             hold_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);
    int lane;

    // First requesting lane at or after ptr_i, wrapping; nothing while held.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        lane    = 0;
        if (!hold_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                lane = (int'(ptr_i) + k) % N_REQ;
                if (!any_o && req_i[lane]) begin
                    grant_o[lane] = 1'b1;
                    idx_o         = ID_W'(lane);
                    any_o         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mod4591_share_arb.sv
// rtl/mod4591_share_arb.sv - round-robin sharing of one mod4591 reducer
module mod4591_share_arb
    import mod4591_share_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TAG_W   = 4,
    parameter int P_WIDTH = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    mod4591_share_arb_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int IN_W = 2 * P_WIDTH;

    logic [N_REQ-1:0]                grant;
    logic [ID_W-1:0]                 gidx;
    logic                            gany;
    logic [IN_W-1:0]                 red_in;
    logic [TAG_W-1:0]                gtag;
    logic [P_WIDTH-1:0]              red_out;

    logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [RED_LAT-1:0]              sh_vld_q, sh_vld_d;
    logic [RED_LAT-1:0][ID_W-1:0]    sh_id_q,  sh_id_d;
    logic [RED_LAT-1:0][TAG_W-1:0]   sh_tag_q, sh_tag_d;

    mod4591_share_arb_rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req_i   (bus.Req_valid),
        .ptr_i   (rr_ptr_q),
        .hold_i  (bus.Hold),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    assign bus.Req_ready = grant;

    // Operand and tag of the granted lane; zero operand when idle.
    always_comb begin
        red_in = '0;
        gtag   = '0;
        if (gany) begin
            red_in = bus.Req_data[int'(gidx)*IN_W +: IN_W];
            gtag   = bus.Req_tag[int'(gidx)*TAG_W +: TAG_W];
        end
    end

    // Pointer advance and shadow pipe shift; the last stage keeps its id/tag
    // when idle so the response bus holds the previous result's labels.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gany) rr_ptr_d = ID_W'(rr_next(int'(gidx), N_REQ));
        sh_vld_d    = {sh_vld_q[RED_LAT-2:0], gany};
        sh_id_d     = sh_id_q;
        sh_tag_d    = sh_tag_q;
        sh_id_d[0]  = gidx;
        sh_tag_d[0] = gtag;
        for (int s = 1; s < RED_LAT - 1; s++) begin
            sh_id_d[s]  = sh_id_q[s-1];
            sh_tag_d[s] = sh_tag_q[s-1];
        end
        if (sh_vld_q[RED_LAT-2]) begin
            sh_id_d[RED_LAT-1]  = sh_id_q[RED_LAT-2];
            sh_tag_d[RED_LAT-1] = sh_tag_q[RED_LAT-2];
        end
    end

    // State registers; reset drops every in-flight result.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rr_ptr_q <= '0;
            sh_vld_q <= '0;
            sh_id_q  <= '0;
            sh_tag_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            sh_vld_q <= sh_vld_d;
            sh_id_q  <= sh_id_d;
            sh_tag_q <= sh_tag_d;
        end
    end

    mod4591 #(
        .P_WIDTH (P_WIDTH)
    ) u_mod4591 (
        .Clk   (Clk),
        .Reset (~Reset_n),
        .In    (red_in),
        .Out   (red_out)
    );

    assign bus.Res_valid = sh_vld_q[RED_LAT-1];
    assign bus.Res_id    = sh_id_q[RED_LAT-1];
    assign bus.Res_tag   = sh_tag_q[RED_LAT-1];
    assign bus.Res_data  = red_out;
    assign bus.Busy      = |sh_vld_q;

endmodule

// File: tb/tb_mod4591_share_arb.sv
// tb/tb_mod4591_share_arb.sv - self-checking bench for mod4591_share_arb
module tb_mod4591_share_arb;

    localparam int N     = 4;
    localparam int TAG_W = 4;
    localparam int PW    = 16;
    localparam int Q     = 4591;

    typedef struct {
        int unsigned id;
        int unsigned tag;
        int unsigned data;
    } exp_t;

    logic clk = 1'b0;
    logic Reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    exp_t        sb_q[$];
    logic [N-1:0] hs;
    int          n_grants  = 0;
    int          n_results = 0;
    int          wait_cnt[N];
    int          max_wait = 0;

    mod4591_share_arb_if #(.N_REQ(N), .TAG_W(TAG_W), .P_WIDTH(PW)) bus ();

    mod4591_share_arb #(.N_REQ(N), .TAG_W(TAG_W), .P_WIDTH(PW)) dut (
        .Clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input int unsigned d, input int unsigned t);
        bus.Req_valid[i]              = v;
        bus.Req_data[i*2*PW +: 2*PW]  = d[2*PW-1:0];
        bus.Req_tag[i*TAG_W +: TAG_W] = t[TAG_W-1:0];
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, 0, 0);
    endtask

    // Scoreboard: every handshake expects one result RED_LAT cycles later.
    always @(negedge clk) begin
        exp_t e;
        hs = bus.Req_valid & bus.Req_ready;
        if (!Reset_n) begin
            sb_q.delete();
        end else begin
            if (bus.Res_valid) begin
                n_results++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_id",   64'(bus.Res_id),   64'(e.id));
                    check("sb_tag",  64'(bus.Res_tag),  64'(e.tag));
                    check("sb_data", 64'(bus.Res_data), 64'(e.data));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    e.id   = i;
                    e.tag  = 32'(bus.Req_tag[i*TAG_W +: TAG_W]);
                    e.data = 32'(bus.Req_data[i*2*PW +: 2*PW]) % Q;
                    sb_q.push_back(e);
                    n_grants++;
                end
            end
        end
    end

    initial begin
        int unsigned td[N];
        int unsigned exp_d[N];
        Reset_n  = 1'b0;
        bus.Hold = 1'b0;
        clear_lanes();
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // ---- 1: reset state, single request latency and Busy window
        cyc(); cyc();
        @(negedge clk);
        check("rst_valid", 64'(bus.Res_valid), 0);
        check("rst_id",    64'(bus.Res_id),    0);
        check("rst_tag",   64'(bus.Res_tag),   0);
        check("rst_busy",  64'(bus.Busy),      0);
        check("rst_data",  64'(bus.Res_data),  0);
        cyc();
        Reset_n = 1'b1;
        set_lane(0, 1'b1, 21072707, 5);
        @(negedge clk);
        check("t1_ready", 64'(bus.Req_ready), 64'b0001);
        cyc();
        clear_lanes();
        @(negedge clk);
        check("t1_busy1",  64'(bus.Busy), 1);
        check("t1_nores1", 64'(bus.Res_valid), 0);
        cyc();
        @(negedge clk);
        check("t1_busy2", 64'(bus.Busy), 1);
        cyc();
        @(negedge clk);
        check("t1_valid", 64'(bus.Res_valid), 1);
        check("t1_id",    64'(bus.Res_id),    0);
        check("t1_tag",   64'(bus.Res_tag),   5);
        check("t1_data",  64'(bus.Res_data),  17);
        check("t1_busy3", 64'(bus.Busy),      1);
        cyc();
        @(negedge clk);
        check("t1_vlow",  64'(bus.Res_valid), 0);
        check("t1_bidle", 64'(bus.Busy),      0);
        check("t1_thold", 64'(bus.Res_tag),   5);

        // ---- 2/3: all lanes continuous from ptr 0, back-to-back results
        cyc();
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        td[0] = 4590;     exp_d[0] = 4590;
        td[1] = 21068100; exp_d[1] = 1;
        td[2] = 0;        exp_d[2] = 0;
        td[3] = 4591;     exp_d[3] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) set_lane(i, c < 8, td[i], 8 + i);
            @(negedge clk);
            if (c < 8) check("t2_grant", 64'(bus.Req_ready), 64'(1 << (c % 4)));
            else       check("t2_nogrant", 64'(bus.Req_ready), 0);
            if (c >= 3 && c < 11) begin
                check("t2_valid", 64'(bus.Res_valid), 1);
                check("t2_id",    64'(bus.Res_id),    64'((c - 3) % 4));
                check("t2_data",  64'(bus.Res_data),  64'(exp_d[(c - 3) % 4]));
            end else begin
                check("t2_gap", 64'(bus.Res_valid), 0);
            end
            cyc();
        end

        // ---- 4: Hold blocks grants, in-flight results still drain
        set_lane(0, 1'b1, 9182, 1);
        set_lane(2, 1'b1, 4592, 2);
        @(negedge clk);
        check("t4_g0", 64'(bus.Req_ready), 64'b0001);
        cyc();
        @(negedge clk);
        check("t4_g1", 64'(bus.Req_ready), 64'b0100);
        cyc();
        bus.Hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_ready", 64'(bus.Req_ready), 0);
            check("t4_hold_res",   64'(bus.Res_valid), 64'(k == 1 || k == 2));
            if (k == 1) check("t4_id0", 64'(bus.Res_id), 0);
            if (k == 2) check("t4_id2", 64'(bus.Res_id), 2);
            cyc();
        end
        bus.Hold = 1'b0;
        @(negedge clk);
        check("t4_resume", 64'(bus.Req_ready), 64'b0001);
        cyc();
        clear_lanes();
        for (int k = 0; k < 4; k++) cyc();

        // ---- 5: reset while three results are in flight
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        set_lane(0, 1'b1, 100, 7);
        set_lane(1, 1'b1, 200, 9);
        set_lane(2, 1'b1, 300, 11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_grant", 64'(bus.Req_ready), 64'(1 << k));
            cyc();
        end
        clear_lanes();
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        set_lane(1, 1'b1, 459133, 6);
        set_lane(3, 1'b1, 5, 3);
        @(negedge clk);
        check("t5_ptr0",  64'(bus.Req_ready), 64'b0010);
        check("t5_valid", 64'(bus.Res_valid), 0);
        check("t5_id",    64'(bus.Res_id),    0);
        check("t5_tag",   64'(bus.Res_tag),   0);
        check("t5_data",  64'(bus.Res_data),  0);
        check("t5_busy",  64'(bus.Busy),      0);
        cyc();
        set_lane(1, 1'b0, 0, 0);
        @(negedge clk);
        check("t5_g3",     64'(bus.Req_ready), 64'b1000);
        check("t5_flush1", 64'(bus.Res_valid), 0);
        cyc();
        set_lane(3, 1'b0, 0, 0);
        @(negedge clk);
        check("t5_flush2", 64'(bus.Res_valid), 0);
        cyc();
        @(negedge clk);
        check("t5_rvalid", 64'(bus.Res_valid), 1);
        check("t5_rid",    64'(bus.Res_id),    1);
        check("t5_rtag",   64'(bus.Res_tag),   6);
        check("t5_rdata",  64'(bus.Res_data),  33);
        for (int k = 0; k < 4; k++) cyc();

        // ---- 6: random traffic against the scoreboard, starvation bound
        n_grants  = 0;
        n_results = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.Req_valid[i] && !hs[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end else begin
                    wait_cnt[i] = 0;
                    if ($urandom_range(0, 3) != 0)
                        set_lane(i, 1'b1, $urandom_range(0, Q * Q - 1), $urandom_range(0, 15));
                    else
                        set_lane(i, 1'b0, 0, 0);
                end
            end
            @(negedge clk);
            cyc();
        end
        clear_lanes();
        for (int k = 0; k < 6; k++) cyc();
        check("t6_starve",  64'(max_wait <= N - 1), 1);
        check("t6_count",   64'(n_results), 64'(n_grants));
        check("t6_nonzero", 64'(n_grants > 1000), 1);
        check("t6_sb_left", 64'(sb_q.size()), 0);
        check("t6_busy",    64'(bus.Busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
